// File: rtl/uart_burst_rx_if.sv
// rtl/uart_burst_rx_if.sv - serial input and byte/frame result bundle for uart_burst_rx
interface uart_burst_rx_if #(
  parameter int TOTAL_BYTES = 8
);
  logic                     rx;
  logic [7:0]               byte_data;
  logic                     byte_valid;
  logic                     framing_error;
  logic [8*TOTAL_BYTES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_dropped;
  logic                     busy;

  modport master (
    output rx,
    input  byte_data, byte_valid, framing_error,
    input  frame_data, frame_valid, frame_dropped, busy
  );

  modport slave (
    input  rx,
    output byte_data, byte_valid, framing_error,
    output frame_data, frame_valid, frame_dropped, busy
  );
endinterface

// File: rtl/uart_burst_rx.sv
// rtl/uart_burst_rx.sv - 8N1 receiver that assembles bursts of TOTAL_BYTES bytes into one frame word
// Bit FSM samples mid-bit from the start edge; the assembler drops partial frames on gap or framing error.
module uart_burst_rx #(
  parameter int CLOCKS_PER_BIT = 52,
  parameter int TOTAL_BYTES    = 8,
  parameter int GAP_CLOCKS     = 2080
) (
  input  logic          clk,
  input  logic          reset_n,
  uart_burst_rx_if.slave bus
);
  localparam int IW = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam int GW = $clog2(GAP_CLOCKS + 1);
  localparam int FW = 8 * TOTAL_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t         state_q;
  logic [15:0]    cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic [7:0]     byte_data_q;
  logic           byte_valid_q;
  logic           framing_error_q;
  logic           busy_q;
  logic [1:0]     sync_q;
  logic           rxs;

  logic [IW-1:0]  idx_q;
  logic [GW-1:0]  gap_q;
  logic [FW-1:0]  staging_q;
  logic [FW-1:0]  staging_d;
  logic [FW-1:0]  frame_data_q;
  logic           frame_valid_q;
  logic           frame_dropped_q;

  logic           stop_edge;
  logic           byte_fire;
  logic           ferr_fire;
  logic           timeout;
  logic [IW-1:0]  eidx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], bus.rx};
  end
  assign rxs = sync_q[1];

  assign stop_edge = (state_q == S_STOP) && (cnt_q == 16'(CLOCKS_PER_BIT - 1));
  assign byte_fire = stop_edge && rxs;
  assign ferr_fire = stop_edge && !rxs;
  assign timeout   = (idx_q != '0) && (gap_q == GW'(GAP_CLOCKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      byte_data_q     <= '0;
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == 16'(CLOCKS_PER_BIT / 2 - 1)) begin
            cnt_q <= '0;
            bit_q <= '0;
            if (!rxs) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == 16'(CLOCKS_PER_BIT - 1)) begin
            shift_q <= {rxs, shift_q[7:1]};
            cnt_q   <= '0;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_STOP: begin
          if (stop_edge) begin
            cnt_q <= '0;
            if (rxs) begin
              byte_data_q  <= shift_q;
              byte_valid_q <= 1'b1;
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_BREAK: begin
          // A line held low must go high before another start bit is honoured.
          if (rxs) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A timeout coinciding with a new byte restarts the frame with that byte at index 0.
  always_comb begin
    eidx      = timeout ? '0 : idx_q;
    staging_d = staging_q;
    if (byte_fire) staging_d[8*eidx +: 8] = shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q           <= '0;
      gap_q           <= '0;
      staging_q       <= '0;
      frame_data_q    <= '0;
      frame_valid_q   <= 1'b0;
      frame_dropped_q <= 1'b0;
    end else begin
      frame_valid_q   <= 1'b0;
      frame_dropped_q <= timeout || (ferr_fire && (idx_q != '0));
      staging_q       <= staging_d;

      if (byte_fire || (idx_q == '0))       gap_q <= '0;
      else if (gap_q != GW'(GAP_CLOCKS))    gap_q <= gap_q + 1'b1;

      if (byte_fire) begin
        if (eidx == IW'(TOTAL_BYTES - 1)) begin
          idx_q         <= '0;
          frame_data_q  <= staging_d;
          frame_valid_q <= 1'b1;
        end else begin
          idx_q <= eidx + 1'b1;
        end
      end else if (timeout || ferr_fire) begin
        idx_q <= '0;
      end
    end
  end

  assign bus.byte_data     = byte_data_q;
  assign bus.byte_valid    = byte_valid_q;
  assign bus.framing_error = framing_error_q;
  assign bus.frame_data    = frame_data_q;
  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_dropped = frame_dropped_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_uart_burst_rx.sv
// tb/tb_uart_burst_rx.sv - directed bench for uart_burst_rx
module tb_uart_burst_rx;
  localparam int CPB = 52;
  localparam int TB  = 8;
  localparam int GAP = 2080;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_burst_rx_if #(.TOTAL_BYTES(TB)) bus ();

  uart_burst_rx #(.CLOCKS_PER_BIT(CPB), .TOTAL_BYTES(TB), .GAP_CLOCKS(GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int bv_n = 0, fv_n = 0, fe_n = 0, fd_n = 0, fvbv_n = 0, fefd_n = 0, long_n = 0;
  int bv_cyc = 0, fd_cyc = 0, t_start = 0;
  logic [7:0]  bv_last = '0;
  logic [63:0] fv_last = '0;
  logic [3:0]  prev_p = '0;
  logic [3:0]  cur_p;

  int s_bv, s_fv, s_fe, s_fd, s_fvbv, s_fefd;
  int lat, bv3;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    cur_p = {bus.byte_valid, bus.frame_valid, bus.framing_error, bus.frame_dropped};
    if ((cur_p & prev_p) != 4'b0) long_n++;
    prev_p = cur_p;
    if (bus.byte_valid) begin bv_n++; bv_last = bus.byte_data; bv_cyc = cyc; end
    if (bus.frame_valid) begin
      fv_n++; fv_last = bus.frame_data;
      if (bus.byte_valid) fvbv_n++;
    end
    if (bus.framing_error) begin
      fe_n++;
      if (bus.frame_dropped) fefd_n++;
    end
    if (bus.frame_dropped) begin fd_n++; fd_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_bv = bv_n; s_fv = fv_n; s_fe = fe_n; s_fd = fd_n; s_fvbv = fvbv_n; s_fefd = fefd_n;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx = 1'b0;
    t_start = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      idle(CPB);
    end
    bus.rx = stop_bit;
    idle(CPB);
    bus.rx = 1'b1;
  endtask

  task automatic burst(input logic [7:0] base);
    for (int i = 0; i < TB; i++) send_byte(base + 8'(i), 1'b1);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.rx  = 1'b1;
    idle(3);
    chk("rst_byte_data",     64'(bus.byte_data), 64'h0);
    chk("rst_byte_valid",    64'(bus.byte_valid), 64'h0);
    chk("rst_framing_error", 64'(bus.framing_error), 64'h0);
    chk("rst_frame_data",    bus.frame_data, 64'h0);
    chk("rst_frame_valid",   64'(bus.frame_valid), 64'h0);
    chk("rst_frame_dropped", 64'(bus.frame_dropped), 64'h0);
    chk("rst_busy",          64'(bus.busy), 64'h0);
    reset_n = 1'b1;
    idle(5);

    // single byte
    snap();
    send_byte(8'hA5, 1'b1);
    idle(60);
    lat = bv_cyc - t_start;
    chk("t1_bv_count",  64'(bv_n - s_bv), 64'd1);
    chk("t1_byte_data", 64'(bv_last), 64'hA5);
    chk("t1_fe_count",  64'(fe_n - s_fe), 64'd0);
    chk("t1_fv_count",  64'(fv_n - s_fv), 64'd0);
    chk("t1_busy",      64'(bus.busy), 64'h0);
    chk("t1_latency_in_window", 64'((lat >= 495 && lat <= 497) ? 1 : 0), 64'd1);
    idle(2200);
    chk("t1_partial_dropped", 64'(fd_n - s_fd), 64'd1);

    // full burst 0x00..0x07
    snap();
    burst(8'h00);
    idle(60);
    chk("t2_bv_count",    64'(bv_n - s_bv), 64'd8);
    chk("t2_fv_count",    64'(fv_n - s_fv), 64'd1);
    chk("t2_fv_with_bv",  64'(fvbv_n - s_fvbv), 64'd1);
    chk("t2_frame_data",  fv_last, 64'h0706050403020100);
    chk("t2_frame_out",   bus.frame_data, 64'h0706050403020100);
    chk("t2_fd_count",    64'(fd_n - s_fd), 64'd0);

    // 10-clock glitch, then a clean byte
    snap();
    bus.rx = 1'b0;
    idle(10);
    bus.rx = 1'b1;
    idle(60);
    chk("t3_busy_after_glitch", 64'(bus.busy), 64'h0);
    chk("t3_bv_count",          64'(bv_n - s_bv), 64'd0);
    chk("t3_fe_count",          64'(fe_n - s_fe), 64'd0);
    send_byte(8'h3C, 1'b1);
    idle(60);
    chk("t3_bv_after",   64'(bv_n - s_bv), 64'd1);
    chk("t3_byte_data",  64'(bv_last), 64'h3C);
    idle(2200);

    // bad stop bit on index 3
    snap();
    send_byte(8'h20, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h23, 1'b0);
    idle(60);
    chk("t4_fe_count",      64'(fe_n - s_fe), 64'd1);
    chk("t4_fe_with_fd",    64'(fefd_n - s_fefd), 64'd1);
    chk("t4_fd_count",      64'(fd_n - s_fd), 64'd1);
    chk("t4_fv_count",      64'(fv_n - s_fv), 64'd0);
    chk("t4_byte_data_hold", 64'(bus.byte_data), 64'h22);
    chk("t4_busy",          64'(bus.busy), 64'h0);
    snap();
    burst(8'h10);
    idle(60);
    chk("t4_fv_count_clean", 64'(fv_n - s_fv), 64'd1);
    chk("t4_frame_data",     fv_last, 64'h1716151413121110);

    // gap timeout after three bytes
    snap();
    send_byte(8'h30, 1'b1);
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    idle(10);
    bv3 = bv_cyc;
    idle(3000);
    chk("t5_fd_count",        64'(fd_n - s_fd), 64'd1);
    chk("t5_gap_delay",       64'(fd_cyc - bv3), 64'(GAP));
    chk("t5_fv_count",        64'(fv_n - s_fv), 64'd0);
    chk("t5_frame_data_hold", bus.frame_data, 64'h1716151413121110);
    snap();
    burst(8'h40);
    idle(60);
    chk("t5_fv_after",   64'(fv_n - s_fv), 64'd1);
    chk("t5_frame_data", fv_last, 64'h4746454443424140);

    // reset in the middle of byte 5
    for (int i = 0; i < 4; i++) send_byte(8'h50 + 8'(i), 1'b1);
    bus.rx = 1'b0;
    idle(CPB);
    bus.rx = 1'b1;
    idle(150);
    snap();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_byte_data",  64'(bus.byte_data), 64'h0);
    chk("t6_rst_frame_data", bus.frame_data, 64'h0);
    chk("t6_rst_busy",       64'(bus.busy), 64'h0);
    chk("t6_rst_byte_valid", 64'(bus.byte_valid), 64'h0);
    idle(20);
    chk("t6_rst_no_pulses", 64'((bv_n - s_bv) + (fv_n - s_fv) + (fe_n - s_fe) + (fd_n - s_fd)), 64'd0);
    reset_n = 1'b1;
    idle(10);
    snap();
    burst(8'h60);
    idle(60);
    chk("t6_bv_count",   64'(bv_n - s_bv), 64'd8);
    chk("t6_fv_count",   64'(fv_n - s_fv), 64'd1);
    chk("t6_frame_data", fv_last, 64'h6766656463626160);
    chk("t6_fd_count",   64'(fd_n - s_fd), 64'd0);

    chk("pulse_width_one_cycle", 64'(long_n), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
